// File: rtl/zuc_nlf_pkg.sv
// ZUC nonlinear function F: shared state encodings, S-box tables and linear transforms.
// Used by zuc_nlf (optional pipelining via ZUC_NLF_PIPE_EN) and zuc_nlf_sbox32.
package zuc_nlf_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SBOX = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   // S0 table, entry 0 first
   localparam logic [0:255][7:0] S0_TAB = {
      8'h3e,8'h72,8'h5b,8'h47,8'hca,8'he0,8'h00,8'h33,8'h04,8'hd1,8'h54,8'h98,8'h09,8'hb9,8'h6d,8'hcb,
      8'h7b,8'h1b,8'hf9,8'h32,8'haf,8'h9d,8'h6a,8'ha5,8'hb8,8'h2d,8'hfc,8'h1d,8'h08,8'h53,8'h03,8'h90,
      8'h4d,8'h4e,8'h84,8'h99,8'he4,8'hce,8'hd9,8'h91,8'hdd,8'hb6,8'h85,8'h48,8'h8b,8'h29,8'h6e,8'hac,
      8'hcd,8'hc1,8'hf8,8'h1e,8'h73,8'h43,8'h69,8'hc6,8'hb5,8'hbd,8'hfd,8'h39,8'h63,8'h20,8'hd4,8'h38,
      8'h76,8'h7d,8'hb2,8'ha7,8'hcf,8'hed,8'h57,8'hc5,8'hf3,8'h2c,8'hbb,8'h14,8'h21,8'h06,8'h55,8'h9b,
      8'he3,8'hef,8'h5e,8'h31,8'h4f,8'h7f,8'h5a,8'ha4,8'h0d,8'h82,8'h51,8'h49,8'h5f,8'hba,8'h58,8'h1c,
      8'h4a,8'h16,8'hd5,8'h17,8'ha8,8'h92,8'h24,8'h1f,8'h8c,8'hff,8'hd8,8'hae,8'h2e,8'h01,8'hd3,8'had,
      8'h3b,8'h4b,8'hda,8'h46,8'heb,8'hc9,8'hde,8'h9a,8'h8f,8'h87,8'hd7,8'h3a,8'h80,8'h6f,8'h2f,8'hc8,
      8'hb1,8'hb4,8'h37,8'hf7,8'h0a,8'h22,8'h13,8'h28,8'h7c,8'hcc,8'h3c,8'h89,8'hc7,8'hc3,8'h96,8'h56,
      8'h07,8'hbf,8'h7e,8'hf0,8'h0b,8'h2b,8'h97,8'h52,8'h35,8'h41,8'h79,8'h61,8'ha6,8'h4c,8'h10,8'hfe,
      8'hbc,8'h26,8'h95,8'h88,8'h8a,8'hb0,8'ha3,8'hfb,8'hc0,8'h18,8'h94,8'hf2,8'he1,8'he5,8'he9,8'h5d,
      8'hd0,8'hdc,8'h11,8'h66,8'h64,8'h5c,8'hec,8'h59,8'h42,8'h75,8'h12,8'hf5,8'h74,8'h9c,8'haa,8'h23,
      8'h0e,8'h86,8'hab,8'hbe,8'h2a,8'h02,8'he7,8'h67,8'he6,8'h44,8'ha2,8'h6c,8'hc2,8'h93,8'h9f,8'hf1,
      8'hf6,8'hfa,8'h36,8'hd2,8'h50,8'h68,8'h9e,8'h62,8'h71,8'h15,8'h3d,8'hd6,8'h40,8'hc4,8'he2,8'h0f,
      8'h8e,8'h83,8'h77,8'h6b,8'h25,8'h05,8'h3f,8'h0c,8'h30,8'hea,8'h70,8'hb7,8'ha1,8'he8,8'ha9,8'h65,
      8'h8d,8'h27,8'h1a,8'hdb,8'h81,8'hb3,8'ha0,8'hf4,8'h45,8'h7a,8'h19,8'hdf,8'hee,8'h78,8'h34,8'h60};

   // S1 table, entry 0 first
   localparam logic [0:255][7:0] S1_TAB = {
      8'h55,8'hc2,8'h63,8'h71,8'h3b,8'hc8,8'h47,8'h86,8'h9f,8'h3c,8'hda,8'h5b,8'h29,8'haa,8'hfd,8'h77,
      8'h8c,8'hc5,8'h94,8'h0c,8'ha6,8'h1a,8'h13,8'h00,8'he3,8'ha8,8'h16,8'h72,8'h40,8'hf9,8'hf8,8'h42,
      8'h44,8'h26,8'h68,8'h96,8'h81,8'hd9,8'h45,8'h3e,8'h10,8'h76,8'hc6,8'ha7,8'h8b,8'h39,8'h43,8'he1,
      8'h3a,8'hb5,8'h56,8'h2a,8'hc0,8'h6d,8'hb3,8'h05,8'h22,8'h66,8'hbf,8'hdc,8'h0b,8'hfa,8'h62,8'h48,
      8'hdd,8'h20,8'h11,8'h06,8'h36,8'hc9,8'hc1,8'hcf,8'hf6,8'h27,8'h52,8'hbb,8'h69,8'hf5,8'hd4,8'h87,
      8'h7f,8'h84,8'h4c,8'hd2,8'h9c,8'h57,8'ha4,8'hbc,8'h4f,8'h9a,8'hdf,8'hfe,8'hd6,8'h8d,8'h7a,8'heb,
      8'h2b,8'h53,8'hd8,8'h5c,8'ha1,8'h14,8'h17,8'hfb,8'h23,8'hd5,8'h7d,8'h30,8'h67,8'h73,8'h08,8'h09,
      8'hee,8'hb7,8'h70,8'h3f,8'h61,8'hb2,8'h19,8'h8e,8'h4e,8'he5,8'h4b,8'h93,8'h8f,8'h5d,8'hdb,8'ha9,
      8'had,8'hf1,8'hae,8'h2e,8'hcb,8'h0d,8'hfc,8'hf4,8'h2d,8'h46,8'h6e,8'h1d,8'h97,8'he8,8'hd1,8'he9,
      8'h4d,8'h37,8'ha5,8'h75,8'h5e,8'h83,8'h9e,8'hab,8'h82,8'h9d,8'hb9,8'h1c,8'he0,8'hcd,8'h49,8'h89,
      8'h01,8'hb6,8'hbd,8'h58,8'h24,8'ha2,8'h5f,8'h38,8'h78,8'h99,8'h15,8'h90,8'h50,8'hb8,8'h95,8'he4,
      8'hd0,8'h91,8'hc7,8'hce,8'hed,8'h0f,8'hb4,8'h6f,8'ha0,8'hcc,8'hf0,8'h02,8'h4a,8'h79,8'hc3,8'hde,
      8'ha3,8'hef,8'hea,8'h51,8'he6,8'h6b,8'h18,8'hec,8'h1b,8'h2c,8'h80,8'hf7,8'h74,8'he7,8'hff,8'h21,
      8'h5a,8'h6a,8'h54,8'h1e,8'h41,8'h31,8'h92,8'h35,8'hc4,8'h33,8'h07,8'h0a,8'hba,8'h7e,8'h0e,8'h34,
      8'h88,8'hb1,8'h98,8'h7c,8'hf3,8'h3d,8'h60,8'h6c,8'h7b,8'hca,8'hd3,8'h1f,8'h32,8'h65,8'h04,8'h28,
      8'h64,8'hbe,8'h85,8'h9b,8'h2f,8'h59,8'h8a,8'hd7,8'hb0,8'h25,8'hac,8'haf,8'h12,8'h03,8'he2,8'hf2};

   function automatic logic [7:0] zuc_s0(input logic [7:0] b);
      return S0_TAB[b];
   endfunction

   function automatic logic [7:0] zuc_s1(input logic [7:0] b);
      return S1_TAB[b];
   endfunction

   function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] zuc_l1(input logic [31:0] x);
      return x ^ rotl32(x, 2) ^ rotl32(x, 10) ^ rotl32(x, 18) ^ rotl32(x, 24);
   endfunction

   function automatic logic [31:0] zuc_l2(input logic [31:0] x);
      return x ^ rotl32(x, 8) ^ rotl32(x, 14) ^ rotl32(x, 22) ^ rotl32(x, 30);
   endfunction

endpackage

// File: rtl/zuc_nlf_sbox32.sv
// 32-bit ZUC S-box layer: S0 on bytes 3 and 1, S1 on bytes 2 and 0.
module zuc_nlf_sbox32
   import zuc_nlf_pkg::*;
(
   input  logic [31:0] x,
   output logic [31:0] y
);

   // one table lookup per byte lane, odd lanes use S0
   for (genvar i = 0; i < 4; i++) begin : g_byte
      if (i % 2 == 1) begin : g_s0
         assign y[8*i +: 8] = zuc_s0(x[8*i +: 8]);
      end else begin : g_s1
         assign y[8*i +: 8] = zuc_s1(x[8*i +: 8]);
      end
   end

endmodule

// File: rtl/zuc_nlf.sv
// ZUC nonlinear function F with memory cells R1/R2 and a valid/ready handshake.
// ZUC_NLF_PIPE_EN: register W/L1/L2 at accept and run the S-box layer plus
// R1/R2 write in a following SBOX cycle (2-cycle latency, 1 word per 2 cycles).
module zuc_nlf
   import zuc_nlf_pkg::*;
#(
   parameter int W_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               init,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W_WIDTH-1:0] x0,
   input  logic [W_WIDTH-1:0] x1,
   input  logic [W_WIDTH-1:0] x2,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W_WIDTH-1:0] w
);

   localparam int H = W_WIDTH / 2;

   logic [1:0]         state;
   logic [W_WIDTH-1:0] r1, r2;
   logic [W_WIDTH-1:0] w_nxt, w1, w2, l1_out, l2_out;
   logic [W_WIDTH-1:0] s1_in, s2_in, s1_out, s2_out;
   logic               accept;

   // init blocks acceptance so it always wins over a handshake
   assign in_ready  = !rst && !init &&
                      ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == ST_HOLD);

   // F arithmetic on the current R1/R2 plus the linear layers
   always_comb begin
      w_nxt  = (x0 ^ r1) + r2;
      w1     = r1 + x1;
      w2     = r2 ^ x2;
      l1_out = zuc_l1({w1[H-1:0], w2[W_WIDTH-1:H]});
      l2_out = zuc_l2({w2[H-1:0], w1[W_WIDTH-1:H]});
   end

`ifdef ZUC_NLF_PIPE_EN
   logic [W_WIDTH-1:0] l1_q, l2_q;

   // capture linear-layer outputs for the S-box cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l1_q <= '0;
         l2_q <= '0;
      end else if (accept) begin
         l1_q <= l1_out;
         l2_q <= l2_out;
      end
   end

   assign s1_in = l1_q;
   assign s2_in = l2_q;
`else
   assign s1_in = l1_out;
   assign s2_in = l2_out;
`endif

   zuc_nlf_sbox32 u_sbox_r1 (.x(s1_in), .y(s1_out));
   zuc_nlf_sbox32 u_sbox_r2 (.x(s2_in), .y(s2_out));

   // FSM, R-cells and output word; w only moves on accept so it holds under stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         r1    <= '0;
         r2    <= '0;
         w     <= '0;
      end else if (init) begin
         state <= ST_IDLE;
         r1    <= '0;
         r2    <= '0;
      end else begin
         case (state)
`ifdef ZUC_NLF_PIPE_EN
            ST_SBOX: begin
               r1    <= s1_out;
               r2    <= s2_out;
               state <= ST_HOLD;
            end
`endif
            default: begin
               if (accept) begin
                  w     <= w_nxt;
`ifdef ZUC_NLF_PIPE_EN
                  state <= ST_SBOX;
`else
                  r1    <= s1_out;
                  r2    <= s2_out;
                  state <= ST_HOLD;
`endif
               end else if ((state == ST_HOLD) && out_ready) begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule
